keypad_entry_ctrl: RTL

//   Code-entry controller that sits behind the 4x4 matrix keypad scanner (Keyboard).
//   It consumes the debounced key code and press level, and assembles a DIGITS-long code
//   in a shift buffer. Keys A/B/C act as enter, backspace and clear.
//   It compares the entry against code_ref and sequences open, error and lockout phases

---
 rtl/keypad_entry_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - keypad code-entry controller with open, error and lockout sequencing
//
// Purpose: turns debounced keypad presses into a DIGITS-long hex code, checks it
// against code_ref and drives unlock/error/locked for display and actuator logic.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   key_num      debounced key code (0-F); digits 0-9, A=enter, B=backspace, C=clear
//   key_pressed  debounced press level
//   code_ref     reference code, nibble [3:0] is the last digit entered
//   entry        current entry, right-justified, [3:0] newest digit
//   entry_cnt    digits currently in the buffer
//   unlock       high throughout OPEN
//   error        one-cycle pulse on a failed check
//   locked       high throughout LOCKOUT
//   state        IDLE=0 ENTRY=1 CHECK=2 OPEN=3 LOCKOUT=4
module keypad_entry_ctrl #(
  parameter int DIGITS      = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int OPEN_CYC    = 3000,
  parameter int LOCK_CYC    = 10000,
  parameter int MAX_FAIL    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            key_num,
  input  logic                  key_pressed,
  input  logic [4*DIGITS-1:0]   code_ref,
  output logic [4*DIGITS-1:0]   entry,
  output logic [2:0]            entry_cnt,
  output logic                  unlock,
  output logic                  error,
  output logic                  locked,
  output logic [2:0]            state
);

  localparam int EW      = 4 * DIGITS;
  localparam int MAX_AB  = (TIMEOUT_CYC > OPEN_CYC) ? TIMEOUT_CYC : OPEN_CYC;
  localparam int MAX_CYC = (MAX_AB > LOCK_CYC) ? MAX_AB : LOCK_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int FW      = $clog2(MAX_FAIL + 1);

  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] OPEN_LAST    = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] LOCK_LAST    = TW'(LOCK_CYC - 1);
  localparam logic [FW-1:0] FAIL_LAST    = FW'(MAX_FAIL - 1);
  localparam logic [2:0]    CNT_FULL     = 3'(DIGITS);

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t          cur, nxt;
  logic [EW-1:0]   entry_nx;
  logic [2:0]      cnt_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [FW-1:0]   fail_cnt, fail_nx;
  logic            key_pressed_d;
  logic            armed;
  logic            ev;
  logic            is_digit;
  logic            match;

  // armed stays low until the key has been seen released after reset, so a key
  // held through reset deassertion cannot produce an event.
  assign ev       = key_pressed & ~key_pressed_d & armed;
  assign is_digit = (key_num <= 4'd9);
  assign match    = (entry_cnt == CNT_FULL) && (entry == code_ref);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_pressed_d <= 1'b0;
      armed         <= 1'b0;
    end else begin
      key_pressed_d <= key_pressed;
      armed         <= armed | ~key_pressed;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry     <= '0;
      entry_cnt <= '0;
      timer     <= '0;
      fail_cnt  <= '0;
    end else begin
      entry     <= entry_nx;
      entry_cnt <= cnt_nx;
      timer     <= timer_nx;
      fail_cnt  <= fail_nx;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    nxt      = cur;
    entry_nx = entry;
    cnt_nx   = entry_cnt;
    fail_nx  = fail_cnt;
    timer_nx = timer;
    case (cur)
      S_IDLE: begin
        if (ev && is_digit) begin
          entry_nx = EW'(key_num);
          cnt_nx   = 3'd1;
          nxt      = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (ev) begin
          // Any key, even an ignored one, counts as activity.
          timer_nx = '0;
          if (is_digit) begin
            if (entry_cnt < CNT_FULL) begin
              entry_nx = (entry << 4) | EW'(key_num);
              cnt_nx   = entry_cnt + 3'd1;
            end
          end else if (key_num == KEY_BACK) begin
            entry_nx = entry >> 4;
            cnt_nx   = entry_cnt - 3'd1;
            if (entry_cnt == 3'd1) nxt = S_IDLE;
          end else if (key_num == KEY_CLEAR) begin
            entry_nx = '0;
            cnt_nx   = '0;
            nxt      = S_IDLE;
          end else if (key_num == KEY_ENTER) begin
            nxt = S_CHECK;
          end
        end else if (timer == TIMEOUT_LAST) begin
          entry_nx = '0;
          cnt_nx   = '0;
          nxt      = S_IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      S_CHECK: begin
        entry_nx = '0;
        cnt_nx   = '0;
        if (match) begin
          fail_nx = '0;
          nxt     = S_OPEN;
        end else begin
          fail_nx = fail_cnt + 1'b1;
          nxt     = (fail_cnt == FAIL_LAST) ? S_LOCKOUT : S_IDLE;
        end
      end
      S_OPEN: begin
        if ((ev && key_num == KEY_CLEAR) || timer == OPEN_LAST) begin
          nxt = S_IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          fail_nx = '0;
          nxt     = S_IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: begin
        nxt      = S_IDLE;
        entry_nx = '0;
        cnt_nx   = '0;
      end
    endcase
    // Every phase measures its own interval from zero.
    if (nxt != cur) timer_nx = '0;
  end

  // Outputs
  always_comb begin
    unlock = (cur == S_OPEN);
    locked = (cur == S_LOCKOUT);
    error  = (cur == S_CHECK) && !match;
  end

  assign state = cur;

endmodule
